// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_seq
// Purpose  : Registered ALU control decode with multi-cycle mul/div sequencing.
//            Optional divide support is enabled by defining ALU_CTRL_DIV_EN.
// Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_seq #(
    parameter int SEL_W      = 3,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [1:0]       alu_op,
    output logic             out_valid,
    output logic [SEL_W-1:0] sel,
    output logic             illegal,
    output logic             md_start,
    output logic             md_signed,
    output logic             md_div,
    output logic             md_busy,
    output logic             md_done
);

    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_MD_RUN   = 1'b1;
    localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [2:0]       r_sel;
    logic             r_illegal;
    logic             r_md_start;
    logic             r_md_signed;
    logic             r_md_div;

    logic [2:0]       w_dec_sel;
    logic             w_dec_illegal;
    logic             w_dec_md;
    logic             w_dec_div;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_md_busy;
    logic             w_md_done;

    // Instruction decode; mul/div requests leave sel at 000 and illegal low.
    always_comb begin
        w_dec_sel     = 3'b000;
        w_dec_illegal = 1'b0;
        w_dec_md      = 1'b0;
        w_dec_div     = 1'b0;
        case (alu_op)
            2'b00: w_dec_sel = 3'b010;
            2'b01: w_dec_sel = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: w_dec_sel = 3'b010;
                    6'b100001: w_dec_sel = 3'b100;
                    6'b100010: w_dec_sel = 3'b110;
                    6'b100011: w_dec_sel = 3'b110;
                    6'b100100: w_dec_sel = 3'b000;
                    6'b100101: w_dec_sel = 3'b001;
                    6'b000000: w_dec_sel = 3'b101;
                    6'b101010: w_dec_sel = 3'b011;
                    6'b101011: w_dec_sel = 3'b111;
                    6'b011000,
                    6'b011001: w_dec_md = 1'b1;
`ifdef ALU_CTRL_DIV_EN
                    6'b011010,
                    6'b011011: begin
                        w_dec_md  = 1'b1;
                        w_dec_div = 1'b1;
                    end
`endif
                    default:   w_dec_illegal = 1'b1;
                endcase
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    assign w_accept = in_valid & w_in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_accept && w_dec_md) w_state_nxt = c_MD_RUN;
            c_MD_RUN: if (w_md_done)            w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic. The counter is frozen during the md_start cycle so that
    // done lands exactly MUL_CYCLES/DIV_CYCLES cycles after the start pulse.
    always_comb begin
        w_in_ready = (r_state == c_IDLE);
        w_md_done  = (r_state == c_MD_RUN) && !r_md_start && (r_cnt == '0);
        w_md_busy  = (r_state == c_MD_RUN) && !w_md_done;
    end

    // Registered decode results, start pulse and sequence counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sel       <= 3'b000;
            r_illegal   <= 1'b0;
            r_md_start  <= 1'b0;
            r_md_signed <= 1'b0;
            r_md_div    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= w_accept;
            r_md_start  <= w_accept & w_dec_md;
            if (w_accept) begin
                r_sel     <= w_dec_sel;
                r_illegal <= w_dec_illegal;
            end
            if (w_accept && w_dec_md) begin
                r_md_signed <= ~funct[0];
                r_md_div    <= w_dec_div;
                r_cnt       <= w_dec_div ? c_DIV_LOAD : c_MUL_LOAD;
            end else if ((r_state == c_MD_RUN) && !r_md_start && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    generate
        if (SEL_W > 3) begin : g_sel_wide
            assign sel = {{(SEL_W-3){1'b0}}, r_sel};
        end else begin : g_sel_narrow
            assign sel = r_sel;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign illegal   = r_illegal;
    assign md_start  = r_md_start;
    assign md_signed = r_md_signed;
    assign md_div    = r_md_div;
    assign md_busy   = w_md_busy;
    assign md_done   = w_md_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_seq
// Purpose  : Directed self-checking bench for alu_ctrl_seq (default params).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] funct;
    logic [1:0] alu_op;
    logic       out_valid;
    logic [2:0] sel;
    logic       illegal;
    logic       md_start;
    logic       md_signed;
    logic       md_div;
    logic       md_busy;
    logic       md_done;

    int errors = 0;
    int checks = 0;

    alu_ctrl_seq #(
        .SEL_W      (3),
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .sel       (sel),
        .illegal   (illegal),
        .md_start  (md_start),
        .md_signed (md_signed),
        .md_div    (md_div),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles from the md_start cycle until md_done, watching in_ready.
    task automatic wait_done(input string tag, input int exp_n);
        int  n;
        bit  seen;
        bit  rdy_hi;
        n      = 0;
        seen   = 1'b0;
        rdy_hi = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            n++;
            if (in_ready) rdy_hi = 1'b1;
            if (md_done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(exp_n));
        chk({tag, "_ready_low"}, 32'(rdy_hi), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(md_busy), 32'd0);
    endtask

    logic [1:0] v_op  [11];
    logic [5:0] v_fn  [11];
    logic [2:0] v_sel [11];

    initial begin
        v_op[0]  = 2'b10; v_fn[0]  = 6'b100000; v_sel[0]  = 3'd2;
        v_op[1]  = 2'b10; v_fn[1]  = 6'b100001; v_sel[1]  = 3'd4;
        v_op[2]  = 2'b10; v_fn[2]  = 6'b100010; v_sel[2]  = 3'd6;
        v_op[3]  = 2'b10; v_fn[3]  = 6'b100011; v_sel[3]  = 3'd6;
        v_op[4]  = 2'b10; v_fn[4]  = 6'b100100; v_sel[4]  = 3'd0;
        v_op[5]  = 2'b10; v_fn[5]  = 6'b100101; v_sel[5]  = 3'd1;
        v_op[6]  = 2'b10; v_fn[6]  = 6'b000000; v_sel[6]  = 3'd5;
        v_op[7]  = 2'b10; v_fn[7]  = 6'b101010; v_sel[7]  = 3'd3;
        v_op[8]  = 2'b10; v_fn[8]  = 6'b101011; v_sel[8]  = 3'd7;
        v_op[9]  = 2'b00; v_fn[9]  = 6'b111111; v_sel[9]  = 3'd2;
        v_op[10] = 2'b01; v_fn[10] = 6'b000000; v_sel[10] = 3'd6;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        alu_op   = 2'b10;
        funct    = 6'b100000;

        // Reset with a request pending: it must be dropped.
        tick();
        tick();
        chk("rst_outputs", {24'd0, out_valid, sel, illegal, md_start, md_signed, md_div},
            32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_md_done", 32'(md_done), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back single-cycle ops
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            alu_op   = v_op[i];
            funct    = v_fn[i];
            tick();
            chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("b2b%0d_sel", i), 32'(sel), 32'(v_sel[i]));
            chk($sformatf("b2b%0d_illegal", i), 32'(illegal), 32'd0);
            chk($sformatf("b2b%0d_start", i), 32'(md_start), 32'd0);
        end
        in_valid = 1'b0;
        alu_op   = 2'b10;
        funct    = 6'b100101;
        tick();
        chk("hold_valid", 32'(out_valid), 32'd0);
        chk("hold_sel", 32'(sel), 32'd6);

        // Illegal requests
        in_valid = 1'b1;
        alu_op   = 2'b11;
        funct    = 6'b100000;
        tick();
        chk("ill_op_valid", 32'(out_valid), 32'd1);
        chk("ill_op_sel", 32'(sel), 32'd0);
        chk("ill_op_illegal", 32'(illegal), 32'd1);
        alu_op = 2'b10;
        funct  = 6'b111111;
        tick();
        chk("ill_fn_valid", 32'(out_valid), 32'd1);
        chk("ill_fn_sel", 32'(sel), 32'd0);
        chk("ill_fn_illegal", 32'(illegal), 32'd1);
        in_valid = 1'b0;
        tick();

        // MULT with an ADD held behind it
        in_valid = 1'b1;
        alu_op   = 2'b10;
        funct    = 6'b011000;
        tick();
        chk("mult_start", 32'(md_start), 32'd1);
        chk("mult_signed", 32'(md_signed), 32'd1);
        chk("mult_div", 32'(md_div), 32'd0);
        chk("mult_valid", 32'(out_valid), 32'd1);
        chk("mult_sel", 32'(sel), 32'd0);
        chk("mult_illegal", 32'(illegal), 32'd0);
        chk("mult_busy", 32'(md_busy), 32'd1);
        chk("mult_ready", 32'(in_ready), 32'd0);
        funct = 6'b100000;
        wait_done("mult", 4);
        tick();
        chk("post_mult_ready", 32'(in_ready), 32'd1);
        chk("post_mult_nodup", 32'(out_valid), 32'd0);
        tick();
        chk("add_after_mult_valid", 32'(out_valid), 32'd1);
        chk("add_after_mult_sel", 32'(sel), 32'd2);
        in_valid = 1'b0;
        tick();

        // MULTU aborted by reset two cycles after md_start
        in_valid = 1'b1;
        funct    = 6'b011001;
        tick();
        in_valid = 1'b0;
        chk("multu_start", 32'(md_start), 32'd1);
        chk("multu_signed", 32'(md_signed), 32'd0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 32'(md_busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        begin
            bit done_seen;
            done_seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (md_done || md_busy) done_seen = 1'b1;
                tick();
            end
            chk("abort_no_done", 32'(done_seen), 32'd0);
        end

        // DIV
        in_valid = 1'b1;
        alu_op   = 2'b10;
        funct    = 6'b011010;
        tick();
        in_valid = 1'b0;
`ifdef ALU_CTRL_DIV_EN
        chk("div_start", 32'(md_start), 32'd1);
        chk("div_div", 32'(md_div), 32'd1);
        chk("div_signed", 32'(md_signed), 32'd1);
        wait_done("div", 32);
`else
        chk("div_valid", 32'(out_valid), 32'd1);
        chk("div_illegal", 32'(illegal), 32'd1);
        chk("div_sel", 32'(sel), 32'd0);
        begin
            bit start_seen;
            start_seen = md_start;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (md_start || !in_ready) start_seen = 1'b1;
            end
            chk("div_no_start", 32'(start_seen), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
